// File: rtl/irq_ctrl_pkg.sv
// Shared constants for the interrupt controller: register word indices,
// the spurious vector and the bus handshake state encoding.
package irq_ctrl_pkg;

    localparam logic [6:0] REG_PENDING  = 7'd0;
    localparam logic [6:0] REG_ENABLE   = 7'd1;
    localparam logic [6:0] REG_LEVEL_LO = 7'd2;
    localparam logic [6:0] REG_LEVEL_HI = 7'd3;
    localparam logic [6:0] REG_VECBASE  = 7'd4;

    localparam logic [7:0] SPURIOUS_VEC = 8'h18;

    localparam logic [1:0] ST_IDLE     = 2'd0;
    localparam logic [1:0] ST_ACK      = 2'd1;
    localparam logic [1:0] ST_WAIT_REL = 2'd2;

endpackage

// File: rtl/irq_prio_enc.sv
// Combinational priority encoder: highest eligible level for the CPU, and the
// lowest-index eligible source sitting at the level being acknowledged.
module irq_prio_enc #(
    parameter int NUM_SRC = 8
) (
    input  logic [NUM_SRC-1:0]      eligible,
    input  logic [NUM_SRC-1:0][2:0] levels,
    input  logic [2:0]              iack_level,
    output logic [2:0]              cur_level,
    output logic [2:0]              win_idx,
    output logic                    win_valid
);

    always_comb begin
        cur_level = 3'd0;
        win_idx   = 3'd0;
        win_valid = 1'b0;
        // Walking downwards lets the lowest matching index overwrite last.
        for (int i = NUM_SRC - 1; i >= 0; i--) begin
            if (eligible[i] && (levels[i] > cur_level)) begin
                cur_level = levels[i];
            end
            if (eligible[i] && (levels[i] == iack_level)) begin
                win_idx   = 3'(i);
                win_valid = 1'b1;
            end
        end
    end

endmodule

// File: rtl/irq_ctrl.sv
// 68000-style interrupt controller: pending/enable/level registers on the
// 16-bit peripheral bus, registered IPL output and IACK vector generation.
module irq_ctrl
    import irq_ctrl_pkg::*;
#(
    parameter int         NUM_SRC      = 8,
    parameter logic [7:0] VEC_BASE_RST = 8'h40
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic [NUM_SRC-1:0] irq_i,
    input  logic               cs,
    input  logic               iack,
    input  logic [2:0]         iack_level,
    input  logic [7:0]         addr,
    input  logic [15:0]        data_write,
    output logic [15:0]        data_read,
    input  logic               uds,
    input  logic               lds,
    input  logic               rw,
    output logic               ack,
    output logic [2:0]         ipl_n
);

    logic [NUM_SRC-1:0]      pending_reg, pending_next;
    logic [NUM_SRC-1:0]      enable_reg, enable_next;
    logic [NUM_SRC-1:0][2:0] level_reg, level_next;
    logic [7:0]              vecbase_reg, vecbase_next;
    logic [1:0]              state_reg, state_next;
    logic                    ack_reg, ack_next;
    logic [15:0]             data_read_reg, data_read_next;
    logic [2:0]              ipl_n_reg;

    logic [NUM_SRC-1:0]      eligible;
    logic [2:0]              cur_level;
    logic [2:0]              win_idx;
    logic                    win_valid;

    logic [6:0]              reg_idx;
    logic                    access, do_read, do_write, do_iack;
    logic [NUM_SRC-1:0]      w1c_mask, iack_mask;
    logic [15:0]             rd_word;
    logic [7:0]              pend8, en8;
    logic [7:0][2:0]         lvl8;
    logic                    unused_bits;

    assign reg_idx  = addr[7:1];
    // Only the first cycle of a select does anything; the FSM swallows the rest.
    assign access   = (state_reg == ST_IDLE) && (cs || iack);
    assign do_iack  = access && iack;
    assign do_read  = access && !iack && cs && rw;
    assign do_write = access && !iack && cs && !rw;

    assign unused_bits = &{1'b0, addr[0], data_write[15], data_write[11]};

    // Zero-padded 8-source views so the read mux is independent of NUM_SRC.
    generate
        for (genvar gi = 0; gi < 8; gi++) begin : g_view
            if (gi < NUM_SRC) begin : g_live
                assign pend8[gi] = pending_reg[gi];
                assign en8[gi]   = enable_reg[gi];
                assign lvl8[gi]  = level_reg[gi];
            end else begin : g_pad
                assign pend8[gi] = 1'b0;
                assign en8[gi]   = 1'b0;
                assign lvl8[gi]  = 3'd0;
            end
        end
    endgenerate

    generate
        for (genvar gi = 0; gi < NUM_SRC; gi++) begin : g_src
            localparam logic [6:0] WIDX = (gi < 4) ? REG_LEVEL_LO : REG_LEVEL_HI;
            localparam int         LSB  = (gi % 4) * 4;
            logic lane;

            assign lane          = ((gi % 4) >= 2) ? uds : lds;
            assign eligible[gi]  = pending_reg[gi] & enable_reg[gi] & (level_reg[gi] != 3'd0);
            assign level_next[gi] = (do_write && (reg_idx == WIDX) && lane)
                                  ? data_write[LSB +: 3] : level_reg[gi];
        end
    endgenerate

    irq_prio_enc #(
        .NUM_SRC (NUM_SRC)
    ) u_prio_enc (
        .eligible   (eligible),
        .levels     (level_reg),
        .iack_level (iack_level),
        .cur_level  (cur_level),
        .win_idx    (win_idx),
        .win_valid  (win_valid)
    );

    assign w1c_mask = (do_write && (reg_idx == REG_PENDING) && lds)
                    ? data_write[NUM_SRC-1:0] : '0;

    always_comb begin
        iack_mask = '0;
        if (do_iack && win_valid) begin
            iack_mask[win_idx] = 1'b1;
        end
    end

    // A new pulse outranks any clear landing in the same cycle.
    assign pending_next = irq_i | (pending_reg & ~(w1c_mask | iack_mask));
    assign enable_next  = (do_write && (reg_idx == REG_ENABLE) && lds)
                        ? data_write[NUM_SRC-1:0] : enable_reg;
    assign vecbase_next = (do_write && (reg_idx == REG_VECBASE) && lds)
                        ? data_write[7:0] : vecbase_reg;

    always_comb begin
        rd_word = 16'h0000;
        case (reg_idx)
            REG_PENDING:  rd_word = {8'h00, pend8};
            REG_ENABLE:   rd_word = {8'h00, en8};
            REG_LEVEL_LO: rd_word = {1'b0, lvl8[3], 1'b0, lvl8[2], 1'b0, lvl8[1], 1'b0, lvl8[0]};
            REG_LEVEL_HI: rd_word = {1'b0, lvl8[7], 1'b0, lvl8[6], 1'b0, lvl8[5], 1'b0, lvl8[4]};
            REG_VECBASE:  rd_word = {8'h00, vecbase_reg};
            default:      rd_word = 16'h0000;
        endcase
    end

    always_comb begin
        data_read_next = data_read_reg;
        if (do_iack) begin
            data_read_next = {8'h00, win_valid ? (vecbase_reg + {5'b00000, win_idx}) : SPURIOUS_VEC};
        end else if (do_read) begin
            data_read_next = rd_word;
        end else if (do_write) begin
            data_read_next = 16'h0000;
        end
    end

    always_comb begin
        state_next = state_reg;
        ack_next   = 1'b0;
        case (state_reg)
            ST_IDLE: begin
                if (cs || iack) begin
                    state_next = ST_ACK;
                    ack_next   = 1'b1;
                end
            end
            ST_ACK:      state_next = ST_WAIT_REL;
            ST_WAIT_REL: if (!cs && !iack) state_next = ST_IDLE;
            default:     state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pending_reg   <= '0;
            enable_reg    <= '0;
            level_reg     <= '0;
            vecbase_reg   <= VEC_BASE_RST;
            state_reg     <= ST_IDLE;
            ack_reg       <= 1'b0;
            data_read_reg <= 16'h0000;
            ipl_n_reg     <= 3'b111;
        end else begin
            pending_reg   <= pending_next;
            enable_reg    <= enable_next;
            level_reg     <= level_next;
            vecbase_reg   <= vecbase_next;
            state_reg     <= state_next;
            ack_reg       <= ack_next;
            data_read_reg <= data_read_next;
            ipl_n_reg     <= ~cur_level;
        end
    end

    assign data_read = data_read_reg;
    assign ack       = ack_reg;
    assign ipl_n     = ipl_n_reg;

endmodule

// File: tb/tb_irq_ctrl.sv
// Directed bench for irq_ctrl: a vector table of bus/IACK accesses plus
// hand-written sequences for pulse timing, W1C collision and mid-access reset.
module tb_irq_ctrl;

    logic        clk = 1'b0;
    logic        reset_n = 1'b1;
    logic [7:0]  irq_i = '0;
    logic        cs = 1'b0;
    logic        iack = 1'b0;
    logic [2:0]  iack_level = '0;
    logic [7:0]  addr = '0;
    logic [15:0] data_write = '0;
    logic [15:0] data_read;
    logic        uds = 1'b0;
    logic        lds = 1'b0;
    logic        rw = 1'b1;
    logic        ack;
    logic [2:0]  ipl_n;

    int n_pass  = 0;
    int n_total = 0;

    always #5 clk = ~clk;

    irq_ctrl #(
        .NUM_SRC      (8),
        .VEC_BASE_RST (8'h40)
    ) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .irq_i      (irq_i),
        .cs         (cs),
        .iack       (iack),
        .iack_level (iack_level),
        .addr       (addr),
        .data_write (data_write),
        .data_read  (data_read),
        .uds        (uds),
        .lds        (lds),
        .rw         (rw),
        .ack        (ack),
        .ipl_n      (ipl_n)
    );

    typedef struct {
        string       name;
        logic [7:0]  irq_pre;
        logic        is_iack;
        logic        is_rd;
        logic [7:0]  a;
        logic [15:0] wd;
        logic        u;
        logic        l;
        logic [2:0]  lvl;
        int          hold;
        logic [15:0] exp_rd;
        logic [2:0]  exp_ipl;
    } vec_t;

    vec_t vecs[23];

    task automatic check(input string nm, input logic [15:0] act, input logic [15:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h, expected %h", nm, act, exp);
    endtask

    task automatic pulse(input logic [7:0] p);
        @(negedge clk);
        irq_i = p;
        @(negedge clk);
        irq_i = '0;
    endtask

    // One complete access; counts every ack pulse seen during and after it.
    task automatic bus(input logic is_iack, input logic is_rd, input logic [7:0] a,
                       input logic [15:0] wd, input logic u, input logic l,
                       input logic [2:0] lvl, input int hold, input logic [7:0] irq_p,
                       output logic [15:0] rd, output int acks);
        acks = 0;
        @(negedge clk);
        iack = is_iack; cs = !is_iack; rw = is_rd; addr = a;
        data_write = wd; uds = u; lds = l; iack_level = lvl; irq_i = irq_p;
        for (int k = 0; k < hold; k++) begin
            @(posedge clk); #1;
            irq_i = '0;
            if (ack) acks++;
        end
        @(negedge clk);
        cs = 1'b0; iack = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(posedge clk); #1;
            if (ack) acks++;
        end
        rd = data_read;
    endtask

    function automatic vec_t mk(input string nm, input logic [7:0] irq_pre, input logic is_iack,
                                input logic is_rd, input logic [7:0] a, input logic [15:0] wd,
                                input logic u, input logic l, input logic [2:0] lvl, input int hold,
                                input logic [15:0] exp_rd, input logic [2:0] exp_ipl);
        vec_t v;
        v.name = nm; v.irq_pre = irq_pre; v.is_iack = is_iack; v.is_rd = is_rd; v.a = a;
        v.wd = wd; v.u = u; v.l = l; v.lvl = lvl; v.hold = hold;
        v.exp_rd = exp_rd; v.exp_ipl = exp_ipl;
        return v;
    endfunction

    initial begin
        logic [15:0] rd;
        int          acks;

        vecs[0]  = mk("rd_pending_rst", 8'h00, 0, 1, 8'h00, 16'h0000, 1, 1, 0, 5, 16'h0000, 3'b111);
        vecs[1]  = mk("rd_enable_rst",  8'h00, 0, 1, 8'h02, 16'h0000, 1, 1, 0, 5, 16'h0000, 3'b111);
        vecs[2]  = mk("rd_level_lo_rst",8'h00, 0, 1, 8'h04, 16'h0000, 1, 1, 0, 5, 16'h0000, 3'b111);
        vecs[3]  = mk("rd_level_hi_rst",8'h00, 0, 1, 8'h06, 16'h0000, 1, 1, 0, 5, 16'h0000, 3'b111);
        vecs[4]  = mk("rd_vecbase_rst", 8'h00, 0, 1, 8'h08, 16'h0000, 1, 1, 0, 5, 16'h0040, 3'b111);
        vecs[5]  = mk("wr_level_lo",    8'h00, 0, 0, 8'h04, 16'h0052, 1, 1, 0, 1, 16'h0000, 3'b111);
        vecs[6]  = mk("wr_enable",      8'h00, 0, 0, 8'h02, 16'h0003, 0, 1, 0, 1, 16'h0000, 3'b111);
        vecs[7]  = mk("rd_level_lo",    8'h00, 0, 1, 8'h04, 16'h0000, 1, 1, 0, 2, 16'h0052, 3'b111);
        vecs[8]  = mk("rd_pending_03",  8'h03, 0, 1, 8'h00, 16'h0000, 1, 1, 0, 2, 16'h0003, 3'b010);
        vecs[9]  = mk("iack_l5",        8'h00, 1, 1, 8'h00, 16'h0000, 0, 0, 5, 2, 16'h0041, 3'b101);
        vecs[10] = mk("rd_pending_01",  8'h00, 0, 1, 8'h00, 16'h0000, 1, 1, 0, 2, 16'h0001, 3'b101);
        vecs[11] = mk("iack_l2",        8'h00, 1, 1, 8'h00, 16'h0000, 0, 0, 2, 2, 16'h0040, 3'b111);
        vecs[12] = mk("iack_l2_spur",   8'h00, 1, 1, 8'h00, 16'h0000, 0, 0, 2, 2, 16'h0018, 3'b111);
        vecs[13] = mk("wr_level_lo_44", 8'h00, 0, 0, 8'h04, 16'h4004, 1, 1, 0, 1, 16'h0000, 3'b111);
        vecs[14] = mk("wr_enable_09",   8'h00, 0, 0, 8'h02, 16'h0009, 0, 1, 0, 1, 16'h0000, 3'b111);
        vecs[15] = mk("wr_vecbase",     8'h00, 0, 0, 8'h08, 16'hABFE, 1, 1, 0, 1, 16'h0000, 3'b111);
        vecs[16] = mk("rd_vecbase_fe",  8'h00, 0, 1, 8'h08, 16'h0000, 1, 1, 0, 1, 16'h00FE, 3'b111);
        vecs[17] = mk("rd_pending_09",  8'h09, 0, 1, 8'h00, 16'h0000, 1, 1, 0, 1, 16'h0009, 3'b011);
        vecs[18] = mk("iack_l4_src0",   8'h00, 1, 1, 8'h00, 16'h0000, 0, 0, 4, 3, 16'h00FE, 3'b011);
        vecs[19] = mk("iack_l4_wrap",   8'h00, 1, 1, 8'h00, 16'h0000, 0, 0, 4, 1, 16'h0001, 3'b111);
        vecs[20] = mk("rd_unmapped",    8'h00, 0, 1, 8'h0A, 16'h0000, 1, 1, 0, 1, 16'h0000, 3'b111);
        vecs[21] = mk("wr_level_hi_lds",8'h00, 0, 0, 8'h06, 16'h7777, 0, 1, 0, 1, 16'h0000, 3'b111);
        vecs[22] = mk("rd_level_hi",    8'h00, 0, 1, 8'h06, 16'h0000, 1, 1, 0, 1, 16'h0077, 3'b111);

        // Reset state
        #2 reset_n = 1'b0;
        @(negedge clk);
        check("rst_ipl_n", 16'(ipl_n), 16'h0007);
        check("rst_ack", 16'(ack), 16'h0000);
        check("rst_data_read", data_read, 16'h0000);
        @(negedge clk);
        reset_n = 1'b1;

        for (int i = 0; i < 23; i++) begin
            if (vecs[i].irq_pre != 8'h00) pulse(vecs[i].irq_pre);
            bus(vecs[i].is_iack, vecs[i].is_rd, vecs[i].a, vecs[i].wd, vecs[i].u, vecs[i].l,
                vecs[i].lvl, vecs[i].hold, 8'h00, rd, acks);
            $display("vec %0d %s: data_read=%h ipl_n=%b acks=%0d", i, vecs[i].name, rd, ipl_n, acks);
            check({vecs[i].name, "_data"}, rd, vecs[i].exp_rd);
            check({vecs[i].name, "_ipl"}, 16'(ipl_n), 16'(vecs[i].exp_ipl));
            check({vecs[i].name, "_acks"}, 16'(acks), 16'h0001);
        end

        // Pending while disabled stays invisible; enabling shows it one cycle later.
        pulse(8'h10);
        @(posedge clk); #1;
        @(posedge clk); #1;
        check("disabled_ipl", 16'(ipl_n), 16'h0007);
        @(negedge clk);
        cs = 1'b1; rw = 1'b0; addr = 8'h02; data_write = 16'h0010; uds = 1'b0; lds = 1'b1;
        @(posedge clk); #1;
        check("enable_edge_ack", 16'(ack), 16'h0001);
        check("enable_edge_ipl", 16'(ipl_n), 16'h0007);
        @(posedge clk); #1;
        check("enable_next_ipl", 16'(ipl_n), 16'h0000);
        @(negedge clk);
        cs = 1'b0;
        repeat (2) @(posedge clk);
        $display("seq enable_timing: ipl_n=%b", ipl_n);

        // W1C colliding with a new pulse on the same source keeps it pending.
        bus(0, 0, 8'h00, 16'h0001, 0, 1, 0, 1, 8'h01, rd, acks);
        bus(0, 1, 8'h00, 16'h0000, 1, 1, 0, 1, 8'h00, rd, acks);
        $display("seq w1c_collision: pending=%h", rd);
        check("w1c_collision", rd, 16'h0011);
        pulse(8'h02);
        bus(0, 1, 8'h00, 16'h0000, 1, 1, 0, 1, 8'h00, rd, acks);
        check("pending_set_bit1", rd, 16'h0013);
        bus(0, 0, 8'h00, 16'h0002, 0, 1, 0, 1, 8'h00, rd, acks);
        bus(0, 1, 8'h00, 16'h0000, 1, 1, 0, 1, 8'h00, rd, acks);
        $display("seq w1c_plain: pending=%h", rd);
        check("w1c_plain", rd, 16'h0011);
        check("w1c_ipl", 16'(ipl_n), 16'h0000);

        // Reset asserted while ack is high takes effect without waiting for a clock.
        @(negedge clk);
        cs = 1'b1; rw = 1'b1; addr = 8'h00;
        @(posedge clk); #1;
        check("midack_ack_hi", 16'(ack), 16'h0001);
        check("midack_data", data_read, 16'h0011);
        #2 reset_n = 1'b0;
        #1;
        check("midack_ack_lo", 16'(ack), 16'h0000);
        check("midack_ipl", 16'(ipl_n), 16'h0007);
        check("midack_data_rst", data_read, 16'h0000);
        @(negedge clk);
        cs = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
        bus(0, 1, 8'h08, 16'h0000, 1, 1, 0, 1, 8'h00, rd, acks);
        check("post_rst_vecbase", rd, 16'h0040);
        check("post_rst_acks", 16'(acks), 16'h0001);
        bus(0, 1, 8'h00, 16'h0000, 1, 1, 0, 1, 8'h00, rd, acks);
        $display("seq reset_midack: pending=%h ipl_n=%b", rd, ipl_n);
        check("post_rst_pending", rd, 16'h0000);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/irq_ctrl.md
Name: irq_ctrl

Overview:
- 68000-style interrupt controller that consumes the single-cycle interrupt pulses of the UART (tx_send_tick / rx_avail_tick) and other peripherals.
- Latches each pulse as a pending bit and prioritises enabled sources by a programmable level.
- Drives the CPU's active-low IPL lines.
- Answers the interrupt-acknowledge cycle with a vector number through the same 16-bit byte-lane bus interface the peripherals use.

Parameters:
NUM_SRC, 8, number of interrupt sources (1..8)
VEC_BASE_RST, 8'h40, reset value of VECBASE register

Ports:
clk  in  1  system clock
reset_n  in  1  asynchronous active-low reset
irq_i  in  NUM_SRC  interrupt pulses, one clk wide, bit i = source i
cs  in  1  register access select
iack  in  1  CPU interrupt-acknowledge cycle select (mutually exclusive with cs)
iack_level  in  3  level being acknowledged (CPU A3..A1)
addr  in  8  byte address; addr[7:1] selects word register
data_write  in  16  write data
data_read  out  16  read data / vector (vector in [7:0])
uds  in  1  upper byte lane enable
lds  in  1  lower byte lane enable
rw  in  1  1 = read, 0 = write
ack  out  1  bus cycle acknowledge
ipl_n  out  3  encoded interrupt priority level to CPU, active low

Behaviour:
- Reset (async, reset_n low): pending = 0, enable = 0, all levels = 0, vecbase = VEC_BASE_RST, ipl_n = 3'b111, ack = 0, data_read = 0, bus FSM = IDLE.
- Register map, word index addr[7:1]; only listed lanes are stored, all other bits read 0:
  - 0 PENDING: lds [7:0]; read returns pending; write-1-to-clear.
  - 1 ENABLE: lds [7:0]; R/W.
  - 2 LEVEL_LO: sources 0..3, nibble per source, bits [2:0] of each nibble used; uds covers sources 3,2; lds covers sources 1,0.
  - 3 LEVEL_HI: sources 4..7, same layout.
  - 4 VECBASE: lds [7:0]; R/W.
  - Other indices: acked; reads return 0; writes ignored.
- Bits at or above NUM_SRC: read 0, writes ignored.
- Pending:
  - irq_i[i] high → pending[i] set on the next edge.
  - Set wins over W1C or IACK clear in the same cycle.
- Priority:
  - Eligible source = pending & enable & level != 0.
  - cur_level = max level among eligible sources.
  - ipl_n <= ~cur_level, registered; 1 cycle after the pending/enable/level change.
  - Level 0 means masked.
- Bus FSM, states IDLE → ACK → WAIT_REL:
  - IDLE: on cs or iack high, perform the access and set ack = 1, data_read registered in the same edge → ACK.
  - ACK: ack = 0 → WAIT_REL.
  - WAIT_REL: stay until cs and iack are both low → IDLE.
  - Result: exactly one ack pulse and one side effect per access, however long the select is held. Reads have no side effects.
  - data_read holds its value until the next access; it is 0 on write accesses.
- IACK:
  - Winner = lowest-index eligible source whose level == iack_level.
  - If a winner exists: data_read[7:0] = vecbase + index (8-bit wrap); clear pending[index].
  - If none: data_read[7:0] = 8'h18 (spurious vector); no state change.
  - data_read[15:8] = 0.
- Clearing or disabling a source while ipl_n shows its level drops ipl_n on the next cycle. A CPU IACK after that receives the spurious vector.
- Reset mid-access: FSM returns to IDLE and ack drops immediately (async).

Decomposition:
- Package irq_ctrl_pkg:
  - Register index constants REG_PENDING=0, REG_ENABLE=1, REG_LEVEL_LO=2, REG_LEVEL_HI=3, REG_VECBASE=4.
  - SPURIOUS_VEC = 8'h18.
  - Bus FSM state encoding.
- One sub-module, irq_prio_enc: combinational.
  - Inputs: eligible mask, levels, iack_level.
  - Outputs: cur_level, and the winner index plus a valid flag for iack_level.
- Register file and bus FSM stay in irq_ctrl.

Test Plan:
- Reset, then read all five registers → 0, 0, 0, 0, 8'h40; ipl_n = 3'b111; exactly one ack per access with cs held 5 cycles.
- LEVEL_LO = 16'h0052 (src0 = 2, src1 = 5), ENABLE = 8'h03, pulse irq_i = 8'h03 → PENDING reads 8'h03; ipl_n = ~3'd5 one cycle after the pulse.
- IACK with iack_level = 5 → data_read = 16'h0041, PENDING = 8'h01, ipl_n = ~3'd2. IACK level 2 → 16'h0040, ipl_n = 3'b111. IACK level 2 again → 16'h0018.
- Two sources (src0 and src3, both level 4), VECBASE = 8'hFE: IACK level 4 → 8'hFE (src0 wins); second IACK level 4 → 8'h01 (8-bit wrap for src3).
- Write PENDING = 8'h01 in the same cycle irq_i[0] pulses → pending[0] stays 1. Write PENDING = 8'h02 with no pulse → bit 1 clears.
- Pending with ENABLE = 0 → ipl_n stays 3'b111. Enable → level appears one cycle later. Assert reset_n low mid-ack → ack and ipl_n go inactive immediately.
